// File: rtl/vx_tensor_hmma_seq.sv
// HMMA macro-op sequencer: expands one warp-level HMMA into four step uops,
// throttles them by commit credits and reports macro-op completion.
module vx_tensor_hmma_seq #(
    parameter int NW_WIDTH     = 2,
    parameter int NR_BITS      = 6,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [NW_WIDTH-1:0] req_wid,
    input  logic [NR_BITS-1:0]  req_rd,
    output logic                uop_valid,
    input  logic                uop_ready,
    output logic [1:0]          uop_step,
    output logic [NW_WIDTH-1:0] uop_wid,
    output logic [NR_BITS-1:0]  uop_rd,
    input  logic                cmt_fire,
    output logic                done_valid,
    input  logic                done_ready,
    output logic [NW_WIDTH-1:0] done_wid,
    output logic                busy,
    output logic                err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [2:0] MAX_IF = 3'(MAX_INFLIGHT);

    state_t              state;
    logic [NW_WIDTH-1:0] wid_q;
    logic [NR_BITS-1:0]  rd_base;
    logic [1:0]          step_cnt;
    logic [2:0]          inflight;
    logic                sub_cnt;
    logic [3:0]          cmt_total;
    logic                err_q;

    logic uop_fire;
    logic cmt_bad;
    logic cmt_ok;
    logic step_done;

    // Credit check looks only at the registered inflight count
    assign uop_valid = (state == S_ISSUE) && (inflight < MAX_IF);
    assign uop_fire  = uop_valid && uop_ready;

    // A commit is only legal while a step is outstanding or half-committed
    assign cmt_bad = cmt_fire &&
                     ((state == S_IDLE) || (state == S_DONE) ||
                      ((inflight == 3'd0) && !sub_cnt));
    assign cmt_ok    = cmt_fire && !cmt_bad;
    assign step_done = cmt_ok && sub_cnt;

    assign req_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign done_valid = (state == S_DONE);
    assign done_wid   = wid_q;
    assign uop_step   = step_cnt;
    assign uop_wid    = wid_q;
    assign uop_rd     = rd_base + NR_BITS'(step_cnt);
    assign err        = err_q;

    // Sequencer state, credit and commit bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            wid_q     <= '0;
            rd_base   <= '0;
            step_cnt  <= '0;
            inflight  <= '0;
            sub_cnt   <= 1'b0;
            cmt_total <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= cmt_bad;
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        wid_q     <= req_wid;
                        rd_base   <= req_rd;
                        step_cnt  <= '0;
                        inflight  <= '0;
                        sub_cnt   <= 1'b0;
                        cmt_total <= '0;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE, S_DRAIN: begin
                    if (uop_fire) begin
                        step_cnt <= step_cnt + 2'd1;
                        if (step_cnt == 2'd3) begin
                            state <= S_DRAIN;
                        end
                    end
                    if (cmt_ok) begin
                        sub_cnt   <= ~sub_cnt;
                        cmt_total <= cmt_total + 4'd1;
                        if ((state == S_DRAIN) && (cmt_total == 4'd7)) begin
                            state <= S_DONE;
                        end
                    end
                    unique case ({uop_fire, step_done})
                        2'b10:   inflight <= inflight + 3'd1;
                        2'b01:   inflight <= inflight - 3'd1;
                        default: inflight <= inflight;
                    endcase
                end
                S_DONE: begin
                    if (done_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vx_tensor_hmma_seq.sv
// Directed bench for vx_tensor_hmma_seq: a cycle table for the basic flow
// plus hand sequences for credits, backpressure, wrap and reset.
module tb_vx_tensor_hmma_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [1:0] req_wid;
    logic [5:0] req_rd;
    logic       uop_ready;
    logic       cmt_fire;
    logic       done_ready;

    logic       rr_o   [3];
    logic       uv_o   [3];
    logic [1:0] st_o   [3];
    logic [1:0] uw_o   [3];
    logic [5:0] urd_o  [3];
    logic       dv_o   [3];
    logic [1:0] dw_o   [3];
    logic       busy_o [3];
    logic       err_o  [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instance 0: MAX_INFLIGHT=4, 1: MAX_INFLIGHT=1, 2: MAX_INFLIGHT=2
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int MI = (g == 0) ? 4 : ((g == 1) ? 1 : 2);
        vx_tensor_hmma_seq #(
            .NW_WIDTH(2),
            .NR_BITS(6),
            .MAX_INFLIGHT(MI)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req_valid (req_valid),
            .req_ready (rr_o[g]),
            .req_wid   (req_wid),
            .req_rd    (req_rd),
            .uop_valid (uv_o[g]),
            .uop_ready (uop_ready),
            .uop_step  (st_o[g]),
            .uop_wid   (uw_o[g]),
            .uop_rd    (urd_o[g]),
            .cmt_fire  (cmt_fire),
            .done_valid(dv_o[g]),
            .done_ready(done_ready),
            .done_wid  (dw_o[g]),
            .busy      (busy_o[g]),
            .err       (err_o[g])
        );
    end

    typedef struct {
        logic       rv;
        logic [5:0] rd;
        logic       ur;
        logic       cmt;
        logic       dr;
        logic       e_rr;
        logic       e_uv;
        logic [1:0] e_st;
        logic [5:0] e_rd;
        logic       e_dv;
        logic       e_busy;
        logic       e_err;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        logic rv, logic [5:0] rd, logic ur, logic cmt, logic dr,
        logic rr, logic uv, logic [1:0] st, logic [5:0] urd,
        logic dv, logic bz, logic er
    );
        vec_t v;
        v.rv = rv; v.rd = rd; v.ur = ur; v.cmt = cmt; v.dr = dr;
        v.e_rr = rr; v.e_uv = uv; v.e_st = st; v.e_rd = urd;
        v.e_dv = dv; v.e_busy = bz; v.e_err = er;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic drive(logic rv, logic [1:0] w, logic [5:0] rd,
                         logic ur, logic c, logic dr);
        req_valid  = rv;
        req_wid    = w;
        req_rd     = rd;
        uop_ready  = ur;
        cmt_fire   = c;
        done_ready = dr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_reset_vals(string tag, int g);
        chk({tag, "_rr"},   rr_o[g],   1);
        chk({tag, "_uv"},   uv_o[g],   0);
        chk({tag, "_st"},   st_o[g],   0);
        chk({tag, "_uw"},   uw_o[g],   0);
        chk({tag, "_urd"},  urd_o[g],  0);
        chk({tag, "_dv"},   dv_o[g],   0);
        chk({tag, "_dw"},   dw_o[g],   0);
        chk({tag, "_busy"}, busy_o[g], 0);
        chk({tag, "_err"},  err_o[g],  0);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int g = 0; g < 3; g++) begin
            chk_reset_vals($sformatf("rst%0d", g), g);
        end

        // Basic flow, done stall and IDLE commit error on instance 0
        vt.push_back(mk(1, 10, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 10, 0, 1, 0));
        vt.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 11, 0, 1, 0));
        vt.push_back(mk(0, 0, 1, 0, 0, 0, 1, 2, 12, 0, 1, 0));
        vt.push_back(mk(0, 0, 1, 1, 0, 0, 1, 3, 13, 0, 1, 0));
        for (int i = 0; i < 7; i++) begin
            vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        end
        for (int i = 0; i < 4; i++) begin
            vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        end
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

        foreach (vt[i]) begin
            vec_t v;
            v = vt[i];
            @(negedge clk);
            chk($sformatf("row%0d_rr", i),   rr_o[0],   v.e_rr);
            chk($sformatf("row%0d_uv", i),   uv_o[0],   v.e_uv);
            chk($sformatf("row%0d_dv", i),   dv_o[0],   v.e_dv);
            chk($sformatf("row%0d_busy", i), busy_o[0], v.e_busy);
            chk($sformatf("row%0d_err", i),  err_o[0],  v.e_err);
            if (v.e_uv) begin
                chk($sformatf("row%0d_step", i), st_o[0],  v.e_st);
                chk($sformatf("row%0d_rd", i),   urd_o[0], v.e_rd);
                chk($sformatf("row%0d_wid", i),  uw_o[0],  2);
            end
            if (v.e_dv) begin
                chk($sformatf("row%0d_dwid", i), dw_o[0], 2);
            end
            drive(v.rv, 2, v.rd, v.ur, v.cmt, v.dr);
        end

        // Credit throttle on instance 1 (one step in flight)
        do_reset();
        drive(1, 1, 5, 0, 0, 0);
        @(negedge clk);
        chk("thr_uv0", uv_o[1], 1);
        chk("thr_st0", st_o[1], 0);
        drive(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("thr_hold_a", uv_o[1], 0);
        @(negedge clk);
        chk("thr_hold_b", uv_o[1], 0);
        cmt_fire = 1'b1;
        @(negedge clk);
        chk("thr_half", uv_o[1], 0);
        @(negedge clk);
        chk("thr_uv1", uv_o[1], 1);
        chk("thr_st1", st_o[1], 1);
        chk("thr_rd1", urd_o[1], 6);
        cmt_fire = 1'b0;

        // Backpressure during step 2 on instance 0
        do_reset();
        drive(1, 1, 20, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("bp_st1", st_o[0], 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_uv_%0d", i), uv_o[0], 1);
            chk($sformatf("bp_st_%0d", i), st_o[0], 2);
            chk($sformatf("bp_rd_%0d", i), urd_o[0], 22);
            uop_ready = 1'b0;
        end
        @(negedge clk);
        chk("bp_st2_last", st_o[0], 2);
        uop_ready = 1'b1;
        @(negedge clk);
        chk("bp_uv3", uv_o[0], 1);
        chk("bp_st3", st_o[0], 3);
        chk("bp_rd3", urd_o[0], 23);

        // Destination register wrap on instance 0
        do_reset();
        drive(1, 0, 62, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            logic [5:0] exp_rd;
            exp_rd = 6'd62 + 6'(i);
            chk($sformatf("wrap_rd_%0d", i), urd_o[0], exp_rd);
            chk($sformatf("wrap_st_%0d", i), st_o[0], i);
            @(negedge clk);
        end

        // Uop fire coinciding with a step-completing commit, instance 2
        do_reset();
        drive(1, 3, 0, 0, 0, 0);
        @(negedge clk);
        chk("sim_c1_uv", uv_o[2], 1);
        drive(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("sim_c2_uv", uv_o[2], 1);
        chk("sim_c2_st", st_o[2], 1);
        drive(0, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk("sim_c3_uv", uv_o[2], 1);
        chk("sim_c3_st", st_o[2], 1);
        drive(0, 0, 0, 1, 1, 0);
        @(negedge clk);
        chk("sim_c4_uv", uv_o[2], 1);
        chk("sim_c4_st", st_o[2], 2);
        chk("sim_c4_err", err_o[2], 0);
        drive(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("sim_c5_uv", uv_o[2], 0);
        uop_ready = 1'b0;

        // Reset after step 1 fires on instance 0
        do_reset();
        drive(1, 1, 8, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("rmid_st1", st_o[0], 1);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_reset_vals("rmid", 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rmid_nodone_%0d", i), dv_o[0], 0);
            chk($sformatf("rmid_idle_%0d", i), rr_o[0], 1);
        end
        drive(1, 3, 40, 0, 0, 0);
        @(negedge clk);
        chk("rmid_new_uv", uv_o[0], 1);
        chk("rmid_new_st", st_o[0], 0);
        chk("rmid_new_rd", urd_o[0], 40);
        chk("rmid_new_wid", uw_o[0], 3);
        drive(0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
